// File: rtl/hazard_controller.sv
// Stall/flush/forwarding control for the five-stage core plus debug halt drain and stall-cycle counter.
// Forwarding and stall/flush are combinational; halt_ack and stall_cycles are registered, with no backpressure.
module hazard_controller #(
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       RS1_D,
   input  logic [4:0]       RS2_D,
   input  logic [4:0]       RS1_E,
   input  logic [4:0]       RS2_E,
   input  logic [4:0]       RD_E,
   input  logic             ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RD_M,
   input  logic             RegWriteM,
   input  logic [4:0]       RD_W,
   input  logic             RegWriteW,
   input  logic             halt_req,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic             halt_ack,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t        state, stateNext;
   logic [DW-1:0] drainCnt, drainCntNext;
   logic          lwStall;

   // Memory stage has priority over writeback; x0 is never forwarded.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS1_E))
         ForwardAE = 2'b10;
      else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS1_E))
         ForwardAE = 2'b01;
      if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS2_E))
         ForwardBE = 2'b10;
      else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS2_E))
         ForwardBE = 2'b01;
   end

   assign lwStall = ResultSrcE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

   always_comb begin
      stateNext    = state;
      drainCntNext = drainCnt;
      StallF       = 1'b0;
      StallD       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      case (state)
         RUN: begin
            if (PCSrcE) begin
               FlushD = 1'b1;
               FlushE = 1'b1;
            end else begin
               StallF = lwStall;
               StallD = lwStall;
               FlushE = lwStall;
            end
            // A resolving branch is flushed before the drain starts.
            if (halt_req && !PCSrcE) begin
               stateNext    = DRAIN;
               drainCntNext = DW'(DRAIN_CYCLES - 1);
            end
         end
         DRAIN: begin
            if (PCSrcE) begin
               FlushD = 1'b1;
               FlushE = 1'b1;
            end else begin
               StallF = 1'b1;
               StallD = 1'b1;
               FlushE = 1'b1;
            end
            if (drainCnt != '0)
               drainCntNext = drainCnt - DW'(1);
            if (!halt_req)
               stateNext = RUN;
            else if (drainCnt == '0)
               stateNext = HALTED;
         end
         HALTED: begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            if (!halt_req)
               stateNext = RUN;
         end
         default: stateNext = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RUN;
         drainCnt     <= '0;
         halt_ack     <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state    <= stateNext;
         drainCnt <= drainCntNext;
         halt_ack <= (stateNext == HALTED);
         if (StallD && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: stimulus queues expected outputs, a negedge monitor compares them.
module tb_hazard_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
   logic        ResultSrcE, PCSrcE, RegWriteM, RegWriteW, halt_req;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallF, StallD, FlushD, FlushE, halt_ack;
   logic [15:0] stall_cycles;

   logic [24:0] expQ[$];
   string       nameQ[$];
   logic [15:0] expCnt;
   int          nChecks = 0;
   int          nFail   = 0;

   always #5 clk = ~clk;

   hazard_controller dut (
      .clk(clk), .rst(rst),
      .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
      .halt_req(halt_req),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .halt_ack(halt_ack), .stall_cycles(stall_cycles)
   );

   task automatic clrIn();
      RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0;
      ResultSrcE = 0; PCSrcE = 0; RD_M = 0; RegWriteM = 0; RD_W = 0; RegWriteW = 0;
   endtask

   // Queue expectation for the current cycle, then advance one edge and update the counter model.
   task automatic chk(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                      input logic sf, input logic sd, input logic fd, input logic fe, input logic ack);
      nameQ.push_back(nm);
      expQ.push_back({fa, fb, sf, sd, fd, fe, ack, expCnt});
      @(posedge clk); #1;
      if (sd && rst && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
   endtask

   initial begin : monitor
      logic [24:0] e, a;
      string       n;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            a = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, halt_ack, stall_cycles};
            nChecks++;
            if (a !== e) begin
               nFail++;
               $display("FAIL %s: got fa=%b fb=%b sf/sd/fd/fe=%b ack=%b cnt=%h, expected fa=%b fb=%b sf/sd/fd/fe=%b ack=%b cnt=%h",
                        n, a[24:23], a[22:21], a[20:17], a[16], a[15:0],
                        e[24:23], e[22:21], e[20:17], e[16], e[15:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b0; halt_req = 1'b0; expCnt = 16'd0;
      clrIn();
      @(posedge clk); #1;
      chk("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0);
      RD_M = 3; RegWriteM = 1; RS1_E = 3;
      chk("reset_fwd", 2'b10, 2'b00, 0, 0, 0, 0, 0);
      clrIn();
      rst = 1'b1;

      RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1; RS1_E = 5;
      chk("fwd_m", 2'b10, 2'b00, 0, 0, 0, 0, 0);
      RegWriteM = 0; RS2_E = 5;
      chk("fwd_w", 2'b01, 2'b01, 0, 0, 0, 0, 0);
      RS1_E = 0; RD_M = 0; RegWriteM = 1;
      chk("fwd_x0", 2'b00, 2'b01, 0, 0, 0, 0, 0);
      RD_M = 9; RS2_E = 9; RD_W = 9;
      chk("fwd_prio_b", 2'b00, 2'b10, 0, 0, 0, 0, 0);

      clrIn(); ResultSrcE = 1; RD_E = 7; RS2_D = 7;
      chk("lu_stall", 2'b00, 2'b00, 1, 1, 0, 1, 0);
      clrIn(); RD_W = 7; RegWriteW = 1; RS2_E = 7;
      chk("lu_fwd_w", 2'b00, 2'b01, 0, 0, 0, 0, 0);
      clrIn(); ResultSrcE = 1; RD_E = 7; RS1_D = 7; PCSrcE = 1;
      chk("br_lu", 2'b00, 2'b00, 0, 0, 1, 1, 0);
      clrIn(); ResultSrcE = 1; RD_E = 0; RS1_D = 0;
      chk("lu_x0", 2'b00, 2'b00, 0, 0, 0, 0, 0);

      clrIn(); halt_req = 1;
      chk("halt_acc", 2'b00, 2'b00, 0, 0, 0, 0, 0);
      chk("drain1",   2'b00, 2'b00, 1, 1, 0, 1, 0);
      chk("drain2",   2'b00, 2'b00, 1, 1, 0, 1, 0);
      chk("drain3",   2'b00, 2'b00, 1, 1, 0, 1, 0);
      chk("halted",   2'b00, 2'b00, 1, 1, 0, 1, 1);
      chk("halted2",  2'b00, 2'b00, 1, 1, 0, 1, 1);
      halt_req = 0;
      chk("halt_drop", 2'b00, 2'b00, 1, 1, 0, 1, 1);
      chk("resume",    2'b00, 2'b00, 0, 0, 0, 0, 0);

      halt_req = 1;
      chk("abort_acc", 2'b00, 2'b00, 0, 0, 0, 0, 0);
      chk("abort_d1",  2'b00, 2'b00, 1, 1, 0, 1, 0);
      halt_req = 0;
      chk("abort_d2",  2'b00, 2'b00, 1, 1, 0, 1, 0);
      chk("abort_run", 2'b00, 2'b00, 0, 0, 0, 0, 0);
      chk("abort_run2", 2'b00, 2'b00, 0, 0, 0, 0, 0);

      halt_req = 1; PCSrcE = 1;
      chk("hbr_run", 2'b00, 2'b00, 0, 0, 1, 1, 0);
      PCSrcE = 0;
      chk("hbr_acc", 2'b00, 2'b00, 0, 0, 0, 0, 0);
      chk("hbr_d1",  2'b00, 2'b00, 1, 1, 0, 1, 0);
      PCSrcE = 1;
      chk("hbr_d2",  2'b00, 2'b00, 0, 0, 1, 1, 0);
      PCSrcE = 0;
      chk("hbr_d3",  2'b00, 2'b00, 1, 1, 0, 1, 0);
      chk("hbr_halted", 2'b00, 2'b00, 1, 1, 0, 1, 1);

      // Asynchronous reset while halted, checked before the next rising edge.
      #1; rst = 1'b0; expCnt = 16'd0;
      chk("rst_async", 2'b00, 2'b00, 0, 0, 0, 0, 0);
      rst = 1'b1;
      chk("rst_rel",  2'b00, 2'b00, 0, 0, 0, 0, 0);
      chk("redrain",  2'b00, 2'b00, 1, 1, 0, 1, 0);

      repeat (65533) @(posedge clk);
      #1;
      expCnt = 16'hFFFE;
      chk("sat_m1", 2'b00, 2'b00, 1, 1, 0, 1, 1);
      chk("sat_0",  2'b00, 2'b00, 1, 1, 0, 1, 1);
      chk("sat_1",  2'b00, 2'b00, 1, 1, 0, 1, 1);
      chk("sat_2",  2'b00, 2'b00, 1, 1, 0, 1, 1);
      chk("sat_3",  2'b00, 2'b00, 1, 1, 0, 1, 1);
      halt_req = 0;

      @(negedge clk); #1;
      if (expQ.size() != 0) begin
         nFail++;
         $display("FAIL drain_queue: %0d expectations left unchecked, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline control block for the five-stage RISC-V core. It sits beside the decode/execute boundary and generates the stall, flush and forwarding controls for the fetch, decode and execute pipeline registers. It also runs a debug halt handshake that drains the pipeline and holds it frozen, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- CNT_W, default 16: width of the stall-cycle counter.
- DRAIN_CYCLES, default 3: number of bubble cycles needed to empty the E, M and W stages.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- RS1_D, RS2_D, input, 5 each: source register fields of the instruction in decode.
- RS1_E, RS2_E, RD_E, input, 5 each: source and destination registers in execute.
- ResultSrcE, input, 1: the instruction in execute is a load.
- PCSrcE, input, 1: a branch resolved taken in execute.
- RD_M, RegWriteM, input, 5 and 1: destination register and write enable in memory.
- RD_W, RegWriteW, input, 5 and 1: destination register and write enable in writeback.
- halt_req, input, 1: debug halt request, level-sensitive.
- ForwardAE, ForwardBE, output, 2 each: execute operand select. 00 selects the register file, 10 selects ALUResultM, 01 selects ResultW.
- StallF, StallD, output, 1 each: hold the PC register / hold the decode register.
- FlushD, FlushE, output, 1 each: clear the decode / execute pipeline register to a bubble on the next edge.
- halt_ack, output, 1: pipeline is drained and frozen (registered).
- stall_cycles, output, CNT_W: saturating count of cycles with StallD=1 (registered).

## Operation
Forwarding (combinational, independent of FSM state):
- ForwardAE=10 when RegWriteM=1, RD_M≠0 and RD_M=RS1_E.
- Otherwise ForwardAE=01 when RegWriteW=1, RD_W≠0 and RD_W=RS1_E.
- Otherwise ForwardAE=00.
- ForwardBE uses the same rules with RS2_E.
- M has priority over W. Register x0 is never forwarded.

Load-use detection:
- lwStall = ResultSrcE=1, RD_E≠0, and (RD_E=RS1_D or RD_E=RS2_D).

State machine (states RUN, DRAIN, HALTED):
- RUN
  - Outputs: StallF=StallD=lwStall; FlushE=lwStall|PCSrcE; FlushD=PCSrcE.
  - When PCSrcE=1 and lwStall=1 together, the branch wins: StallF=StallD=0, FlushD=FlushE=1.
  - Go to DRAIN when halt_req=1 and PCSrcE=0; the drain counter loads DRAIN_CYCLES-1.
  - When halt_req=1 and PCSrcE=1, stay in RUN for that cycle (branch flush first) and enter DRAIN on a later cycle.
- DRAIN
  - Outputs: StallF=StallD=1, FlushE=1, FlushD=0.
  - Exception: when PCSrcE=1, StallF=StallD=0 and FlushD=FlushE=1, so the PC takes the branch target.
  - The counter decrements every cycle. At count 0 with halt_req=1, go to HALTED.
  - halt_req=0 in any DRAIN cycle aborts: return to RUN next cycle; halt_ack is never asserted.
- HALTED
  - Outputs: StallF=StallD=1, FlushE=1, FlushD=0, halt_ack=1.
  - halt_req=0 returns to RUN next cycle; halt_ack drops on that same edge.
  - The instruction held in D resumes intact.

stall_cycles:
- Increments on each edge where StallD=1, in any state.
- Saturates at all-ones and never wraps.

## Timing
- Reset (rst low, asynchronous):
  - Immediately: state=RUN, counter=0, halt_ack=0, stall_cycles=0.
  - StallF, StallD, FlushD and FlushE follow RUN equations, i.e. 0 unless lwStall or PCSrcE.
  - ForwardAE and ForwardBE stay combinational.
- Reset mid-DRAIN or mid-HALTED abandons the halt. With halt_req still 1 after reset release, DRAIN is re-entered on the first edge.
- Load-use: StallF/StallD/FlushE assert in the same cycle as the condition and last exactly one cycle. The next cycle forwards from W.
- Branch: FlushD/FlushE assert in the same cycle PCSrcE=1 and last one cycle.
- Halt latency: halt_ack rises DRAIN_CYCLES+1 edges after the RUN-cycle edge that accepts halt_req. That is 4 edges with the default, provided no branch resolves during drain.
- A taken branch inside DRAIN does not extend or restart the drain count.

## Test plan
- Forwarding:
  - RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1, RS1_E=5 -> ForwardAE=10.
  - Drop RegWriteM -> ForwardAE=01.
  - RS1_E=0 with RD_M=0, RegWriteM=1 -> ForwardAE=00.
- Load-use: ResultSrcE=1, RD_E=7, RS2_D=7 -> StallF=StallD=FlushE=1 for one cycle; stall_cycles goes 0 -> 1.
- Branch plus load-use in the same cycle: PCSrcE=1, lwStall=1 -> FlushD=FlushE=1, StallF=StallD=0; stall_cycles unchanged.
- Halt:
  - Raise halt_req in RUN -> 3 DRAIN cycles with StallD=1, then halt_ack=1 on the 4th edge; stall_cycles increases by 1 per frozen cycle.
  - Drop halt_req -> halt_ack=0 and StallD=0 on the next cycle.
- Abort and reset:
  - Drop halt_req in DRAIN cycle 2 -> RUN next cycle, halt_ack stays 0.
  - Assert rst while HALTED -> halt_ack=0 and stall_cycles=0 immediately, without waiting for a clock edge.
- Saturation: preload the counter via 65,535 stall cycles, then 3 more stall cycles -> stall_cycles holds 0xFFFF.
